// File: rtl/wb_pkg.sv
// Shared types and encodings for the registered write-back stage.
package wb_pkg;

    typedef enum logic [0:0] {
        WB_IDLE = 1'b0,
        WB_WAIT = 1'b1
    } wb_state_e;

    localparam logic [1:0] LWLR_NONE = 2'b00;
    localparam logic [1:0] LWLR_LWL  = 2'b01;
    localparam logic [1:0] LWLR_LWR  = 2'b10;

    // A halfword occupies two adjacent lanes starting on an even lane.
    localparam logic [1:0] HALF_PAIR = 2'b11;
    localparam int unsigned LANE_W   = 32'd8;
    localparam int unsigned HALF_W   = 32'd16;

endpackage

// File: rtl/wb_stage_pipe_if.sv
// MEM-stage to write-back bundle: instruction fields, data-memory response and commit outputs.
interface wb_stage_pipe_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic                  mem_valid_i;
    logic                  wb_ready_o;
    logic                  flush_i;
    logic [REG_AW-1:0]     mem_wa_i;
    logic                  mem_wreg_i;
    logic [DATA_W-1:0]     mem_wd_i;
    logic                  mem_mreg_i;
    logic [DATA_W/8-1:0]   mem_dre_i;
    logic                  mem_sext_i;
    logic [1:0]            mem_lwlr_i;
    logic                  mem_whilo_i;
    logic [2*DATA_W-1:0]   mem_hilo_i;
    logic                  cp0_we_i;
    logic [REG_AW-1:0]     cp0_waddr_i;
    logic [DATA_W-1:0]     cp0_wdata_i;
    logic [DATA_W-1:0]     dm_rdata_i;
    logic                  dm_rvalid_i;
    logic                  wb_stall_o;
    logic [REG_AW-1:0]     wb_wa_o;
    logic                  wb_wreg_o;
    logic [DATA_W-1:0]     wb_wd_o;
    logic                  wb_whilo_o;
    logic [2*DATA_W-1:0]   wb_hilo_o;
    logic                  cp0_we_o;
    logic [REG_AW-1:0]     cp0_waddr_o;
    logic [DATA_W-1:0]     cp0_wdata_o;

    modport master (
        output mem_valid_i, flush_i, mem_wa_i, mem_wreg_i, mem_wd_i, mem_mreg_i,
               mem_dre_i, mem_sext_i, mem_lwlr_i, mem_whilo_i, mem_hilo_i,
               cp0_we_i, cp0_waddr_i, cp0_wdata_i, dm_rdata_i, dm_rvalid_i,
        input  wb_ready_o, wb_stall_o, wb_wa_o, wb_wreg_o, wb_wd_o, wb_whilo_o,
               wb_hilo_o, cp0_we_o, cp0_waddr_o, cp0_wdata_o
    );

    modport slave (
        input  mem_valid_i, flush_i, mem_wa_i, mem_wreg_i, mem_wd_i, mem_mreg_i,
               mem_dre_i, mem_sext_i, mem_lwlr_i, mem_whilo_i, mem_hilo_i,
               cp0_we_i, cp0_waddr_i, cp0_wdata_i, dm_rdata_i, dm_rvalid_i,
        output wb_ready_o, wb_stall_o, wb_wa_o, wb_wreg_o, wb_wd_o, wb_whilo_o,
               wb_hilo_o, cp0_we_o, cp0_waddr_o, cp0_wdata_o
    );
endinterface

// File: rtl/wb_load_align.sv
// Combinational load extraction: lane select, sign/zero extension, optional LWL/LWR merge.
// The merge path is built only when WB_LWLR_EN is defined.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int WORD_SWAP = 1
) (
    input  logic                mreg,
    input  logic [DATA_W/8-1:0] dre,
    input  logic                sext,
    input  logic [1:0]          lwlr,
    input  logic [DATA_W-1:0]   wd,
    input  logic [DATA_W-1:0]   rdata,
    output logic [DATA_W-1:0]   data
);
    localparam int LANES = DATA_W / 8;

    function automatic logic [DATA_W-1:0] swap_bytes(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = {DATA_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            r[LANE_W*i +: LANE_W] = d[LANE_W*(LANES-1-i) +: LANE_W];
        end
        return r;
    endfunction

    logic [LANE_W-1:0] byte_s;
    logic [HALF_W-1:0] half_s;
    logic              half_hit_s;
    logic [DATA_W-1:0] load_s;

    // Select the addressed byte/halfword/word and extend it to full width.
    always_comb begin
        byte_s     = {LANE_W{1'b0}};
        half_s     = {HALF_W{1'b0}};
        half_hit_s = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            byte_s = byte_s | (rdata[LANE_W*i +: LANE_W] & {LANE_W{dre[i]}});
        end
        for (int k = 0; k < LANES/2; k++) begin
            half_s = half_s | (rdata[HALF_W*k +: HALF_W] &
                               {HALF_W{dre == (LANES'(HALF_PAIR) << (2*k))}});
            half_hit_s = half_hit_s | (dre == (LANES'(HALF_PAIR) << (2*k)));
        end
        if (dre == {LANES{1'b1}}) begin
            load_s = (WORD_SWAP != 0) ? swap_bytes(rdata) : rdata;
        end else if ($onehot(dre)) begin
            load_s = sext ? DATA_W'($signed(byte_s)) : DATA_W'(byte_s);
        end else if (half_hit_s) begin
            load_s = sext ? DATA_W'($signed(half_s)) : DATA_W'(half_s);
        end else begin
            load_s = {DATA_W{1'b0}};
        end
    end

`ifdef WB_LWLR_EN
    int                lo_s;
    int                hi_s;
    logic [DATA_W-1:0] shifted_s;
    logic [LANES-1:0]  mask_s;
    logic [DATA_W-1:0] merge_s;

    // Compact the enabled lanes toward the MSB (LWL) or LSB (LWR) and overlay them on wd.
    always_comb begin
        lo_s = 0;
        hi_s = 0;
        for (int i = LANES-1; i >= 0; i--) begin
            lo_s = dre[i] ? i : lo_s;
        end
        for (int i = 0; i < LANES; i++) begin
            hi_s = dre[i] ? i : hi_s;
        end
        if (lwlr == LWLR_LWL) begin
            shifted_s = rdata << (LANE_W * (LANES-1-hi_s));
            mask_s    = dre << (LANES-1-hi_s);
        end else begin
            shifted_s = rdata >> (LANE_W * lo_s);
            mask_s    = dre >> lo_s;
        end
        merge_s = wd;
        for (int j = 0; j < LANES; j++) begin
            merge_s[LANE_W*j +: LANE_W] = mask_s[j] ? shifted_s[LANE_W*j +: LANE_W]
                                                    : wd[LANE_W*j +: LANE_W];
        end
    end

    assign data = !mreg ? wd :
                  ((lwlr == LWLR_LWL) || (lwlr == LWLR_LWR)) ? merge_s : load_s;
`else
    logic unused_lwlr_s;
    assign unused_lwlr_s = ^lwlr;
    assign data          = mreg ? load_s : wd;
`endif

endmodule

// File: rtl/wb_stage_pipe.sv
// Registered write-back stage: accepts MEM results, waits for late loads, pulses commit strobes.
// Optional LWL/LWR merge is enabled with WB_LWLR_EN.
module wb_stage_pipe
    import wb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int WORD_SWAP = 1
) (
    input  logic           cpu_clk,
    input  logic           rst,
    wb_stage_pipe_if.slave bus
);
    localparam int LANES = DATA_W / 8;

    wb_state_e state_r, next_state_s;
    logic      ready_s, take_s, commit_s, latch_s;

    logic [REG_AW-1:0]   hold_wa_r, hold_cp0_waddr_r;
    logic                hold_wreg_r, hold_sext_r, hold_whilo_r, hold_cp0_we_r;
    logic [DATA_W-1:0]   hold_wd_r, hold_cp0_wdata_r;
    logic [LANES-1:0]    hold_dre_r;
    logic [1:0]          hold_lwlr_r;
    logic [2*DATA_W-1:0] hold_hilo_r;

    logic [REG_AW-1:0]   sel_wa_s, sel_cp0_waddr_s;
    logic                sel_wreg_s, sel_mreg_s, sel_sext_s, sel_whilo_s, sel_cp0_we_s;
    logic [DATA_W-1:0]   sel_wd_s, sel_cp0_wdata_s, align_data_s;
    logic [LANES-1:0]    sel_dre_s;
    logic [1:0]          sel_lwlr_s;
    logic [2*DATA_W-1:0] sel_hilo_s;

    logic [REG_AW-1:0]   wa_r, cp0_waddr_r;
    logic                wreg_r, whilo_r, cp0_we_r;
    logic [DATA_W-1:0]   wd_r, cp0_wdata_r;
    logic [2*DATA_W-1:0] hilo_r;

    assign ready_s = (state_r == WB_IDLE);
    assign take_s  = bus.mem_valid_i & ready_s & ~bus.flush_i;

    // Next-state decode: a load without its data parks in WAIT; flush wins over rvalid there.
    always_comb begin
        next_state_s = state_r;
        commit_s     = 1'b0;
        latch_s      = 1'b0;
        case (state_r)
            WB_IDLE: begin
                if (take_s && bus.mem_mreg_i && !bus.dm_rvalid_i) begin
                    latch_s      = 1'b1;
                    next_state_s = WB_WAIT;
                end else begin
                    commit_s     = take_s;
                    next_state_s = WB_IDLE;
                end
            end
            WB_WAIT: begin
                if (bus.flush_i) begin
                    next_state_s = WB_IDLE;
                end else if (bus.dm_rvalid_i) begin
                    commit_s     = 1'b1;
                    next_state_s = WB_IDLE;
                end else begin
                    next_state_s = WB_WAIT;
                end
            end
            default: begin
                next_state_s = WB_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            state_r <= WB_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Holding registers for an instruction waiting on its load data.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            hold_wa_r        <= {REG_AW{1'b0}};
            hold_wreg_r      <= 1'b0;
            hold_wd_r        <= {DATA_W{1'b0}};
            hold_dre_r       <= {LANES{1'b0}};
            hold_sext_r      <= 1'b0;
            hold_lwlr_r      <= 2'b00;
            hold_whilo_r     <= 1'b0;
            hold_hilo_r      <= {(2*DATA_W){1'b0}};
            hold_cp0_we_r    <= 1'b0;
            hold_cp0_waddr_r <= {REG_AW{1'b0}};
            hold_cp0_wdata_r <= {DATA_W{1'b0}};
        end else if (latch_s) begin
            hold_wa_r        <= bus.mem_wa_i;
            hold_wreg_r      <= bus.mem_wreg_i;
            hold_wd_r        <= bus.mem_wd_i;
            hold_dre_r       <= bus.mem_dre_i;
            hold_sext_r      <= bus.mem_sext_i;
            hold_lwlr_r      <= bus.mem_lwlr_i;
            hold_whilo_r     <= bus.mem_whilo_i;
            hold_hilo_r      <= bus.mem_hilo_i;
            hold_cp0_we_r    <= bus.cp0_we_i;
            hold_cp0_waddr_r <= bus.cp0_waddr_i;
            hold_cp0_wdata_r <= bus.cp0_wdata_i;
        end
    end

    // Field source: live MEM inputs in IDLE, held copy in WAIT (held entries are always loads).
    always_comb begin
        if (state_r == WB_IDLE) begin
            sel_wa_s        = bus.mem_wa_i;
            sel_wreg_s      = bus.mem_wreg_i;
            sel_wd_s        = bus.mem_wd_i;
            sel_mreg_s      = bus.mem_mreg_i;
            sel_dre_s       = bus.mem_dre_i;
            sel_sext_s      = bus.mem_sext_i;
            sel_lwlr_s      = bus.mem_lwlr_i;
            sel_whilo_s     = bus.mem_whilo_i;
            sel_hilo_s      = bus.mem_hilo_i;
            sel_cp0_we_s    = bus.cp0_we_i;
            sel_cp0_waddr_s = bus.cp0_waddr_i;
            sel_cp0_wdata_s = bus.cp0_wdata_i;
        end else begin
            sel_wa_s        = hold_wa_r;
            sel_wreg_s      = hold_wreg_r;
            sel_wd_s        = hold_wd_r;
            sel_mreg_s      = 1'b1;
            sel_dre_s       = hold_dre_r;
            sel_sext_s      = hold_sext_r;
            sel_lwlr_s      = hold_lwlr_r;
            sel_whilo_s     = hold_whilo_r;
            sel_hilo_s      = hold_hilo_r;
            sel_cp0_we_s    = hold_cp0_we_r;
            sel_cp0_waddr_s = hold_cp0_waddr_r;
            sel_cp0_wdata_s = hold_cp0_wdata_r;
        end
    end

    wb_load_align #(
        .DATA_W    (DATA_W),
        .WORD_SWAP (WORD_SWAP)
    ) u_align (
        .mreg  (sel_mreg_s),
        .dre   (sel_dre_s),
        .sext  (sel_sext_s),
        .lwlr  (sel_lwlr_s),
        .wd    (sel_wd_s),
        .rdata (bus.dm_rdata_i),
        .data  (align_data_s)
    );

    // Commit registers: one-cycle strobes, payloads forced to zero when their strobe is low.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            wreg_r      <= 1'b0;
            wa_r        <= {REG_AW{1'b0}};
            wd_r        <= {DATA_W{1'b0}};
            whilo_r     <= 1'b0;
            hilo_r      <= {(2*DATA_W){1'b0}};
            cp0_we_r    <= 1'b0;
            cp0_waddr_r <= {REG_AW{1'b0}};
            cp0_wdata_r <= {DATA_W{1'b0}};
        end else begin
            wreg_r      <= commit_s & sel_wreg_s;
            wa_r        <= (commit_s & sel_wreg_s) ? sel_wa_s : {REG_AW{1'b0}};
            wd_r        <= (commit_s & sel_wreg_s) ? align_data_s : {DATA_W{1'b0}};
            whilo_r     <= commit_s & sel_whilo_s;
            hilo_r      <= (commit_s & sel_whilo_s) ? sel_hilo_s : {(2*DATA_W){1'b0}};
            cp0_we_r    <= commit_s & sel_cp0_we_s;
            cp0_waddr_r <= (commit_s & sel_cp0_we_s) ? sel_cp0_waddr_s : {REG_AW{1'b0}};
            cp0_wdata_r <= (commit_s & sel_cp0_we_s) ? sel_cp0_wdata_s : {DATA_W{1'b0}};
        end
    end

    assign bus.wb_ready_o  = ready_s;
    assign bus.wb_stall_o  = (state_r == WB_WAIT);
    assign bus.wb_wreg_o   = wreg_r;
    assign bus.wb_wa_o     = wa_r;
    assign bus.wb_wd_o     = wd_r;
    assign bus.wb_whilo_o  = whilo_r;
    assign bus.wb_hilo_o   = hilo_r;
    assign bus.cp0_we_o    = cp0_we_r;
    assign bus.cp0_waddr_o = cp0_waddr_r;
    assign bus.cp0_wdata_o = cp0_wdata_r;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Randomised bench for wb_stage_pipe against a transaction-level reference model.
module tb_wb_stage_pipe;
    localparam int DATA_W    = 32;
    localparam int REG_AW    = 5;
    localparam int WORD_SWAP = 1;

    logic cpu_clk = 1'b0;
    logic rst     = 1'b1;

    wb_stage_pipe_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

    wb_stage_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW), .WORD_SWAP(WORD_SWAP)) dut (
        .cpu_clk (cpu_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 cpu_clk = ~cpu_clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  wa;
        logic        wreg;
        logic [31:0] wd;
        logic        mreg;
        logic [3:0]  dre;
        logic        sext;
        logic [1:0]  lwlr;
        logic        whilo;
        logic [63:0] hilo;
        logic        cp0_we;
        logic [4:0]  cp0_waddr;
        logic [31:0] cp0_wdata;
    } instr_t;

    // Reference model state: one pending load at most, plus expected commit outputs.
    logic        busy_m = 1'b0;
    instr_t      held_m;
    logic        e_wreg = 1'b0, e_whilo = 1'b0, e_cp0_we = 1'b0;
    logic [4:0]  e_wa = 5'd0, e_cp0_waddr = 5'd0;
    logic [31:0] e_wd = 32'd0, e_cp0_wdata = 32'd0;
    logic [63:0] e_hilo = 64'd0;

    function automatic instr_t live_instr();
        instr_t t;
        t.wa = bus.mem_wa_i;       t.wreg = bus.mem_wreg_i;   t.wd = bus.mem_wd_i;
        t.mreg = bus.mem_mreg_i;   t.dre = bus.mem_dre_i;     t.sext = bus.mem_sext_i;
        t.lwlr = bus.mem_lwlr_i;   t.whilo = bus.mem_whilo_i; t.hilo = bus.mem_hilo_i;
        t.cp0_we = bus.cp0_we_i;   t.cp0_waddr = bus.cp0_waddr_i;
        t.cp0_wdata = bus.cp0_wdata_i;
        return t;
    endfunction

    function automatic logic [31:0] expect_data(instr_t in, logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        int          n;
        if (!in.mreg) return in.wd;
`ifdef WB_LWLR_EN
        if (in.lwlr == 2'b01 || in.lwlr == 2'b10) begin
            logic [31:0] r;
            logic [7:0]  q[$];
            r = in.wd;
            for (int i = 0; i < 4; i++) if (in.dre[i]) q.push_back(rd[8*i +: 8]);
            for (int j = 0; j < q.size(); j++) begin
                if (in.lwlr == 2'b10) r[8*j +: 8] = q[j];
                else r[8*(4-q.size()+j) +: 8] = q[j];
            end
            return r;
        end
`endif
        n = $countones(in.dre);
        if (in.dre == 4'hF) return {rd[7:0], rd[15:8], rd[23:16], rd[31:24]};
        if (n == 1) begin
            b = 8'(rd >> (8 * $clog2(in.dre)));
            return in.sext ? {{24{b[7]}}, b} : {24'h0, b};
        end
        if (in.dre == 4'b0011) h = rd[15:0];
        else if (in.dre == 4'b1100) h = rd[31:16];
        else return 32'h0;
        return in.sext ? {{16{h[15]}}, h} : {16'h0, h};
    endfunction

    task automatic model_reset();
        busy_m = 1'b0;
        e_wreg = 1'b0; e_wa = 5'd0; e_wd = 32'd0; e_whilo = 1'b0; e_hilo = 64'd0;
        e_cp0_we = 1'b0; e_cp0_waddr = 5'd0; e_cp0_wdata = 32'd0;
    endtask

    task automatic model_step();
        instr_t cur, ci;
        logic   commit;
        cur    = live_instr();
        ci     = cur;
        commit = 1'b0;
        model_reset_outputs();
        if (!busy_m) begin
            if (bus.mem_valid_i && !bus.flush_i) begin
                if (!cur.mreg || bus.dm_rvalid_i) commit = 1'b1;
                else begin held_m = cur; busy_m = 1'b1; end
            end
        end else if (bus.flush_i) begin
            busy_m = 1'b0;
        end else if (bus.dm_rvalid_i) begin
            ci = held_m; commit = 1'b1; busy_m = 1'b0;
        end
        if (commit && ci.wreg) begin
            e_wreg = 1'b1; e_wa = ci.wa; e_wd = expect_data(ci, bus.dm_rdata_i);
        end
        if (commit && ci.whilo) begin e_whilo = 1'b1; e_hilo = ci.hilo; end
        if (commit && ci.cp0_we) begin
            e_cp0_we = 1'b1; e_cp0_waddr = ci.cp0_waddr; e_cp0_wdata = ci.cp0_wdata;
        end
    endtask

    task automatic model_reset_outputs();
        e_wreg = 1'b0; e_wa = 5'd0; e_wd = 32'd0; e_whilo = 1'b0; e_hilo = 64'd0;
        e_cp0_we = 1'b0; e_cp0_waddr = 5'd0; e_cp0_wdata = 32'd0;
    endtask

    task automatic check_outputs(input string pfx);
        check_val({pfx, "_wreg"},  bus.wb_wreg_o,   e_wreg);
        check_val({pfx, "_wa"},    bus.wb_wa_o,     e_wa);
        check_val({pfx, "_wd"},    bus.wb_wd_o,     e_wd);
        check_val({pfx, "_whilo"}, bus.wb_whilo_o,  e_whilo);
        check_val({pfx, "_hilo"},  bus.wb_hilo_o,   e_hilo);
        check_val({pfx, "_cp0we"}, bus.cp0_we_o,    e_cp0_we);
        check_val({pfx, "_cp0a"},  bus.cp0_waddr_o, e_cp0_waddr);
        check_val({pfx, "_cp0d"},  bus.cp0_wdata_o, e_cp0_wdata);
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step_check(input string pfx);
        #1;
        check_val({pfx, "_ready"}, bus.wb_ready_o, !busy_m);
        check_val({pfx, "_stall"}, bus.wb_stall_o, busy_m);
        model_step();
        @(posedge cpu_clk);
        #1;
        check_outputs(pfx);
        @(negedge cpu_clk);
    endtask

    task automatic set_idle();
        bus.mem_valid_i = 1'b0; bus.flush_i = 1'b0; bus.mem_wa_i = 5'd0; bus.mem_wreg_i = 1'b0;
        bus.mem_wd_i = 32'd0; bus.mem_mreg_i = 1'b0; bus.mem_dre_i = 4'd0; bus.mem_sext_i = 1'b0;
        bus.mem_lwlr_i = 2'b00; bus.mem_whilo_i = 1'b0; bus.mem_hilo_i = 64'd0;
        bus.cp0_we_i = 1'b0; bus.cp0_waddr_i = 5'd0; bus.cp0_wdata_i = 32'd0;
        bus.dm_rdata_i = 32'd0; bus.dm_rvalid_i = 1'b0;
    endtask

    task automatic set_load(input logic [3:0] dre, input logic sext, input logic [31:0] rd,
                            input logic rv);
        set_idle();
        bus.mem_valid_i = 1'b1; bus.mem_wreg_i = 1'b1; bus.mem_wa_i = 5'd9;
        bus.mem_mreg_i = 1'b1; bus.mem_dre_i = dre; bus.mem_sext_i = sext;
        bus.dm_rdata_i = rd; bus.dm_rvalid_i = rv;
    endtask

    logic [3:0] dre_tab [11] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100,
                                 4'b1111, 4'b0110, 4'b0101, 4'b0000, 4'b1110};

    task automatic rand_inputs();
        bus.mem_valid_i = ($urandom_range(3, 0) != 0);
        bus.flush_i     = ($urandom_range(15, 0) == 0);
        bus.mem_wa_i    = 5'($urandom());
        bus.mem_wreg_i  = ($urandom_range(7, 0) != 0);
        bus.mem_wd_i    = $urandom();
        bus.mem_mreg_i  = $urandom_range(1, 0) == 1;
        bus.mem_dre_i   = dre_tab[$urandom_range(10, 0)];
        bus.mem_sext_i  = $urandom_range(1, 0) == 1;
        bus.mem_lwlr_i  = 2'($urandom_range(3, 0));
        bus.mem_whilo_i = $urandom_range(3, 0) == 0;
        bus.mem_hilo_i  = {$urandom(), $urandom()};
        bus.cp0_we_i    = $urandom_range(3, 0) == 0;
        bus.cp0_waddr_i = 5'($urandom());
        bus.cp0_wdata_i = $urandom();
        bus.dm_rdata_i  = $urandom();
        bus.dm_rvalid_i = $urandom_range(2, 0) == 0;
    endtask

    initial begin
        int stalls;
        set_idle();
        model_reset();
        repeat (2) @(negedge cpu_clk);
        #1;
        check_outputs("rst");
        check_val("rst_ready", bus.wb_ready_o, 1'b1);
        check_val("rst_stall", bus.wb_stall_o, 1'b0);
        rst = 1'b0;
        @(negedge cpu_clk);

        // ALU op commits next cycle and the strobe lasts one cycle.
        set_idle();
        bus.mem_valid_i = 1'b1; bus.mem_wreg_i = 1'b1; bus.mem_wa_i = 5'd3;
        bus.mem_wd_i = 32'h1234_5678;
        step_check("alu");
        check_val("alu_wd_const", bus.wb_wd_o, 32'h1234_5678);
        set_idle();
        step_check("alu_pulse");
        check_val("alu_pulse_const", bus.wb_wreg_o, 1'b0);

        // Signed byte in lane 1 with data already present.
        set_load(4'b0010, 1'b1, 32'h0000_8000, 1'b1);
        step_check("sbyte");
        check_val("sbyte_const", bus.wb_wd_o, 32'hFFFF_FF80);

        // Full word arriving three cycles late.
        set_load(4'b1111, 1'b0, 32'h1122_3344, 1'b0);
        step_check("late_req");
        stalls = 0;
        for (int k = 0; k < 3; k++) begin
            set_idle();
            bus.dm_rdata_i  = 32'h1122_3344;
            bus.dm_rvalid_i = (k == 2);
            #1;
            if (bus.wb_stall_o === 1'b1 && bus.wb_ready_o === 1'b0) stalls++;
            step_check("late_wait");
        end
        check_val("late_stall_cnt", stalls, 3);
        check_val("late_wd_const", bus.wb_wd_o, 32'h4433_2211);

        // Flush and rvalid together in WAIT: nothing commits.
        set_load(4'b1111, 1'b0, 32'h0, 1'b0);
        step_check("flush_req");
        set_idle();
        bus.flush_i = 1'b1; bus.dm_rvalid_i = 1'b1; bus.dm_rdata_i = 32'hDEAD_BEEF;
        step_check("flush_hit");
        check_val("flush_nostrobe", bus.wb_wreg_o, 1'b0);
        set_idle();
        step_check("flush_after");

        // Reset while waiting: no commit afterwards, then a normal ALU op.
        set_load(4'b0001, 1'b0, 32'h0, 1'b0);
        step_check("rstw_req");
        set_idle();
        bus.dm_rvalid_i = 1'b1;
        rst = 1'b1;
        #1;
        model_reset();
        check_val("rstw_ready", bus.wb_ready_o, 1'b1);
        @(negedge cpu_clk);
        check_outputs("rstw_hold");
        rst = 1'b0;
        step_check("rstw_post");
        bus.mem_valid_i = 1'b1; bus.mem_wreg_i = 1'b1; bus.mem_wa_i = 5'd7;
        bus.mem_wd_i = 32'hCAFE_0001; bus.dm_rvalid_i = 1'b0;
        step_check("rstw_alu");
        check_val("rstw_alu_const", bus.wb_wd_o, 32'hCAFE_0001);

`ifdef WB_LWLR_EN
        set_load(4'b0011, 1'b0, 32'hAABB_CCDD, 1'b1);
        bus.mem_lwlr_i = 2'b10; bus.mem_wd_i = 32'h1122_3344;
        step_check("lwr");
        check_val("lwr_const", bus.wb_wd_o, 32'h1122_CCDD);
`endif

        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            step_check("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
